// File: rtl/qspi_rd_buffer.sv
// Read buffer between the QSPI sample register and the AHB read path: FWFT FIFO plus burst beat tracking.
// Optional build macro QSPI_RD_BUF_BSWAP_EN byte-reverses each word before storage.
module qspi_rd_buffer #(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             h_clk,
    input  logic             h_rstn,
    input  logic             push_in,
    input  logic [31:0]      wr_data_in,
    input  logic             pop_in,
    output logic [31:0]      rd_data_out,
    output logic             rd_valid_out,
    output logic             full_out,
    output logic [PTR_W:0]   level_out,
    input  logic             flush_in,
    input  logic             start_burst_in,
    input  logic [4:0]       beats_expected_in,
    output logic             burst_rx_done_out,
    output logic             overflow_out,
    output logic             underflow_out,
    input  logic             clr_err_in,
    output logic [1:0]       burst_state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } burst_state_t;

    localparam logic [PTR_W:0] DEPTH_L = DEPTH[PTR_W:0];

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;
    logic [31:0]      wr_word;
    logic             pop_acc;
    logic             push_acc;
    logic             overflow_set;
    logic             underflow_set;
    logic [4:0]       load_beats;
    logic [4:0]       rem_q;
    logic [4:0]       rem_d;
    burst_state_t     state_q;
    burst_state_t     state_d;

`ifdef QSPI_RD_BUF_BSWAP_EN
    assign wr_word = {wr_data_in[7:0], wr_data_in[15:8], wr_data_in[23:16], wr_data_in[31:24]};
`else
    assign wr_word = wr_data_in;
`endif

    // Handshake: a push is taken when there is room or a pop frees a slot in the same
    // cycle; a pop is taken whenever the FIFO holds a word; flush overrides both.
    assign pop_acc       = pop_in && !flush_in && (level != '0);
    assign push_acc      = push_in && !flush_in && ((level < DEPTH_L) || pop_acc);
    assign overflow_set  = push_in && !flush_in && !push_acc;
    assign underflow_set = pop_in && !flush_in && (level == '0);

    assign rd_valid_out      = (level != '0);
    assign full_out          = (level == DEPTH_L);
    assign level_out         = level;
    assign rd_data_out       = rd_valid_out ? mem[rd_ptr] : 32'd0;
    assign burst_rx_done_out = (state_q == DONE);
    assign burst_state_out   = state_q;

    always_ff @(posedge h_clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_acc && !pop_acc) begin
                level <= level + 1'b1;
            end else if (pop_acc && !push_acc) begin
                level <= level - 1'b1;
            end
        end
    end

    // A fresh error in the same cycle as the clear keeps the flag set.
    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            overflow_out  <= overflow_set | (overflow_out & ~clr_err_in);
            underflow_out <= underflow_set | (underflow_out & ~clr_err_in);
        end
    end

    assign load_beats = (beats_expected_in == 5'd0) ? 5'd16 : beats_expected_in;

    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // A push in the same cycle as start_burst_in counts against the new burst.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (flush_in) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (start_burst_in) begin
            rem_d   = load_beats - {4'd0, push_acc};
            state_d = (push_acc && (load_beats == 5'd1)) ? DONE : ACTIVE;
        end else if ((state_q == ACTIVE) && push_acc) begin
            rem_d = rem_q - 5'd1;
            if (rem_q == 5'd1) begin
                state_d = DONE;
            end
        end
    end

endmodule

// File: tb/tb_qspi_rd_buffer.sv
// Bench for qspi_rd_buffer: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_qspi_rd_buffer;

    logic        h_clk = 1'b0;
    logic        h_rstn;
    logic        push_in;
    logic [31:0] wr_data_in;
    logic        pop_in;
    logic [31:0] rd_data_out;
    logic        rd_valid_out;
    logic        full_out;
    logic [4:0]  level_out;
    logic        flush_in;
    logic        start_burst_in;
    logic [4:0]  beats_expected_in;
    logic        burst_rx_done_out;
    logic        overflow_out;
    logic        underflow_out;
    logic        clr_err_in;
    logic [1:0]  burst_state_out;

    qspi_rd_buffer #(.DEPTH(16)) dut (
        .h_clk             (h_clk),
        .h_rstn            (h_rstn),
        .push_in           (push_in),
        .wr_data_in        (wr_data_in),
        .pop_in            (pop_in),
        .rd_data_out       (rd_data_out),
        .rd_valid_out      (rd_valid_out),
        .full_out          (full_out),
        .level_out         (level_out),
        .flush_in          (flush_in),
        .start_burst_in    (start_burst_in),
        .beats_expected_in (beats_expected_in),
        .burst_rx_done_out (burst_rx_done_out),
        .overflow_out      (overflow_out),
        .underflow_out     (underflow_out),
        .clr_err_in        (clr_err_in),
        .burst_state_out   (burst_state_out)
    );

    always #5 h_clk = ~h_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a word queue, sticky flags and a "beats left" count.
    logic [31:0] m_q[$];
    bit          m_of;
    bit          m_uf;
    bit          m_active;
    bit          m_done;
    int          m_left;

    typedef struct {
        bit          push;
        bit          pop;
        bit          flush;
        bit          start;
        bit          clr;
        logic [4:0]  beats;
        logic [31:0] data;
        int          lvl;
        bit          valid;
        logic [31:0] rdata;
        bit          full;
        bit          done;
        bit          of;
        bit          uf;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef QSPI_RD_BUF_BSWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit p, input bit po, input bit f, input bit s,
                              input logic [4:0] b, input bit c, input logic [31:0] d);
        bit pop_ok, push_ok, of_set, uf_set;
        of_set = 0;
        uf_set = 0;
        if (f) begin
            m_q.delete();
            m_active = 0;
            m_done   = 0;
        end else begin
            pop_ok  = po && (m_q.size() > 0);
            push_ok = p && ((m_q.size() < 16) || pop_ok);
            uf_set  = po && (m_q.size() == 0);
            of_set  = p && !push_ok;
            if (pop_ok) void'(m_q.pop_front());
            if (push_ok) m_q.push_back(sw(d));
            if (s) begin
                m_left   = (b == 0) ? 16 : int'(b);
                m_active = 1;
                m_done   = 0;
            end
            if (push_ok && m_active) begin
                m_left--;
                if (m_left == 0) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
        m_of = of_set | (m_of & !c);
        m_uf = uf_set | (m_uf & !c);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_of = 0; m_uf = 0; m_active = 0; m_done = 0; m_left = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".level"}, 32'(level_out), 32'(m_q.size()));
        chk({tag, ".valid"}, 32'(rd_valid_out), 32'(m_q.size() > 0));
        chk({tag, ".rdata"}, rd_data_out, (m_q.size() > 0) ? m_q[0] : 32'd0);
        chk({tag, ".full"}, 32'(full_out), 32'(m_q.size() == 16));
        chk({tag, ".done"}, 32'(burst_rx_done_out), 32'(m_done));
        chk({tag, ".ovf"}, 32'(overflow_out), 32'(m_of));
        chk({tag, ".udf"}, 32'(underflow_out), 32'(m_uf));
        chk({tag, ".state"}, 32'(burst_state_out), m_done ? 32'd2 : (m_active ? 32'd1 : 32'd0));
    endtask

    task automatic step(input bit p, input bit po, input bit f, input bit s,
                        input logic [4:0] b, input bit c, input logic [31:0] d);
        push_in = p; pop_in = po; flush_in = f; start_burst_in = s;
        beats_expected_in = b; clr_err_in = c; wr_data_in = d;
        @(posedge h_clk);
        model_step(p, po, f, s, b, c, d);
        #1;
        push_in = 0; pop_in = 0; flush_in = 0; start_burst_in = 0; clr_err_in = 0;
    endtask

    initial begin
        h_rstn = 0;
        push_in = 0; pop_in = 0; flush_in = 0; start_burst_in = 0;
        clr_err_in = 0; beats_expected_in = '0; wr_data_in = '0;
        model_reset();

        //            push pop fl st clr beats data            lvl v rdata                 full done of uf st
        tbl[0]  = '{1, 0, 0, 0, 0, 5'd0, 32'h11223344, 1, 1, sw(32'h11223344), 0, 0, 0, 0, 2'd0};
        tbl[1]  = '{1, 0, 0, 0, 0, 5'd0, 32'hAABBCCDD, 2, 1, sw(32'h11223344), 0, 0, 0, 0, 2'd0};
        tbl[2]  = '{0, 1, 0, 0, 0, 5'd0, 32'h0,        1, 1, sw(32'hAABBCCDD), 0, 0, 0, 0, 2'd0};
        tbl[3]  = '{0, 1, 0, 0, 0, 5'd0, 32'h0,        0, 0, 32'h0,            0, 0, 0, 0, 2'd0};
        tbl[4]  = '{0, 1, 0, 0, 0, 5'd0, 32'h0,        0, 0, 32'h0,            0, 0, 0, 1, 2'd0};
        tbl[5]  = '{0, 0, 0, 0, 1, 5'd0, 32'h0,        0, 0, 32'h0,            0, 0, 0, 0, 2'd0};
        tbl[6]  = '{0, 1, 0, 0, 1, 5'd0, 32'h0,        0, 0, 32'h0,            0, 0, 0, 1, 2'd0};
        tbl[7]  = '{0, 0, 0, 0, 1, 5'd0, 32'h0,        0, 0, 32'h0,            0, 0, 0, 0, 2'd0};
        tbl[8]  = '{1, 0, 0, 1, 0, 5'd4, 32'h000000A0, 1, 1, sw(32'h000000A0), 0, 0, 0, 0, 2'd1};
        tbl[9]  = '{1, 0, 0, 0, 0, 5'd0, 32'h000000A1, 2, 1, sw(32'h000000A0), 0, 0, 0, 0, 2'd1};
        tbl[10] = '{1, 0, 0, 0, 0, 5'd0, 32'h000000A2, 3, 1, sw(32'h000000A0), 0, 0, 0, 0, 2'd1};
        tbl[11] = '{1, 0, 0, 0, 0, 5'd0, 32'h000000A3, 4, 1, sw(32'h000000A0), 0, 1, 0, 0, 2'd2};
        tbl[12] = '{0, 0, 0, 0, 0, 5'd0, 32'h0,        4, 1, sw(32'h000000A0), 0, 1, 0, 0, 2'd2};
        tbl[13] = '{1, 0, 0, 0, 0, 5'd0, 32'h000000A4, 5, 1, sw(32'h000000A0), 0, 1, 0, 0, 2'd2};
        tbl[14] = '{1, 1, 1, 0, 0, 5'd0, 32'h000000A5, 0, 0, 32'h0,            0, 0, 0, 0, 2'd0};

        // Reset state
        repeat (2) @(posedge h_clk);
        #1;
        check_model("reset");
        h_rstn = 1;
        @(posedge h_clk);
        #1;
        check_model("post_reset");

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].flush, tbl[i].start, tbl[i].beats,
                 tbl[i].clr, tbl[i].data);
            chk($sformatf("tbl%0d.level", i), 32'(level_out), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d.valid", i), 32'(rd_valid_out), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d.rdata", i), rd_data_out, tbl[i].rdata);
            chk($sformatf("tbl%0d.full", i), 32'(full_out), 32'(tbl[i].full));
            chk($sformatf("tbl%0d.done", i), 32'(burst_rx_done_out), 32'(tbl[i].done));
            chk($sformatf("tbl%0d.ovf", i), 32'(overflow_out), 32'(tbl[i].of));
            chk($sformatf("tbl%0d.udf", i), 32'(underflow_out), 32'(tbl[i].uf));
            chk($sformatf("tbl%0d.state", i), 32'(burst_state_out), 32'(tbl[i].st));
        end

        // Fill to full, overflow, then push+pop while full
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 5'd0, 0, 32'h5000_0000 + i);
            check_model("fill");
        end
        chk("full_flag", 32'(full_out), 32'd1);
        chk("full_level", 32'(level_out), 32'd16);
        step(1, 0, 0, 0, 5'd0, 0, 32'h0BAD_0BAD);
        chk("ovf_set", 32'(overflow_out), 32'd1);
        chk("ovf_level", 32'(level_out), 32'd16);
        step(1, 1, 0, 0, 5'd0, 0, 32'hDEAD_BEEF);
        chk("full_pp_level", 32'(level_out), 32'd16);
        chk("full_pp_head", rd_data_out, sw(32'h5000_0001));
        for (int i = 0; i < 15; i++) begin
            step(0, 1, 0, 0, 5'd0, 0, 32'h0);
            check_model("drain");
        end
        chk("tail_word", rd_data_out, sw(32'hDEAD_BEEF));
        step(0, 1, 0, 0, 5'd0, 1, 32'h0);
        check_model("drain_last");

        // beats_expected_in = 0 means a 16-word burst
        step(0, 0, 0, 1, 5'd0, 0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0, 0, 5'd0, 0, $urandom);
        end
        chk("b16_not_done", 32'(burst_rx_done_out), 32'd0);
        step(1, 0, 0, 0, 5'd0, 0, $urandom);
        chk("b16_done", 32'(burst_rx_done_out), 32'd1);
        check_model("b16");
        step(0, 0, 1, 0, 5'd0, 0, 32'h0);
        check_model("b16_flush");

        // Asynchronous reset mid-burst with seven words stored
        step(1, 0, 0, 1, 5'd10, 0, 32'h7000_0000);
        for (int i = 1; i < 7; i++) begin
            step(1, 0, 0, 0, 5'd0, 0, 32'h7000_0000 + i);
        end
        chk("pre_rst_level", 32'(level_out), 32'd7);
        chk("pre_rst_state", 32'(burst_state_out), 32'd1);
        #2;
        h_rstn = 0;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge h_clk);
        #1;
        h_rstn = 1;
        check_model("rst_release");

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(99) < 55, $urandom_range(99) < 45, $urandom_range(99) < 3,
                 $urandom_range(99) < 8, 5'($urandom_range(16)), $urandom_range(99) < 6,
                 $urandom);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
